// File: rtl/psola_pkg.sv
// psola_pkg
//   Shared types and default parameters for the PSOLA pitch-shifting datapath.
//   The pitch detector, the frame sequencer and the PSOLA core all import
//   these so that window length and period limits stay consistent.
//
//   seq_state_e      : frame sequencer state encoding
//   DEF_*            : default window / period parameters
//   DROP_COUNT_MAX   : saturation value of the dropped-frame counter
package psola_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PITCH = 2'd1,
        WAIT_PSOLA = 2'd2
    } seq_state_e;

    localparam int DEF_WINDOW_SIZE = 2048;
    localparam int DEF_TAU_WIDTH   = 11;
    localparam int DEF_TAU_MIN     = 20;
    localparam int DEF_TAU_MAX     = 1024;
    localparam int DEF_DEFAULT_TAU = 200;

    localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/window_counter.sv
// window_counter
//   Counts accepted audio samples into fixed-size windows. Produces a
//   combinational boundary strobe on the last sample of a window and owns the
//   registered ping-pong toggle that selects the write half of the sample and
//   output buffers.
//
//   clk_in           in   system clock
//   rst_n_in         in   asynchronous active-low reset
//   sample_valid_in  in   one sample accepted this cycle
//   boundary_out     out  sample_valid_in on the last sample of the window
//   toggle_out       out  current write half; inverts after each boundary
module window_counter
    import psola_pkg::*;
#(
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sample_valid_in,
    output logic boundary_out,
    output logic toggle_out
);

    localparam int CNT_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW_SIZE - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             toggle_q, toggle_d;

    assign boundary_out = sample_valid_in && (count_q == LAST_SAMPLE);
    assign toggle_out   = toggle_q;

    always_comb begin
        count_d  = count_q;
        toggle_d = toggle_q;
        if (sample_valid_in) begin
            // Explicit wrap keeps the counter correct even if the window is
            // ever made a non-power-of-two.
            count_d = boundary_out ? '0 : count_q + 1'b1;
        end
        if (boundary_out) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q  <= '0;
            toggle_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            toggle_q <= toggle_d;
        end
    end

endmodule

// File: rtl/psola_frame_sequencer.sv
// psola_frame_sequencer
//   Per-window sequencer between the pitch detector and the PSOLA core.
//   Starts the detector at each window boundary, validates the returned
//   period, falls back to the last good period for unvoiced/out-of-range
//   frames and issues exactly one period per window when the core is idle.
//   A frame still pending at the next boundary is dropped and counted.
//
//   Handshakes: pitch_valid_in is a single-cycle qualifier honoured only in
//   WAIT_PITCH; psola_idle_in is a level sampled only in WAIT_PSOLA, and a
//   period is transferred on the cycle both WAIT_PSOLA and psola_idle_in hold.
//   tau_valid_out is the one-cycle transfer strobe; tau_out/voiced_out hold.
//
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   sample_valid_in             audio sample accepted this cycle
//   pitch_start_out             one-cycle detector start pulse
//   pitch_tau_in/pitch_valid_in detector result
//   psola_idle_in               PSOLA core can accept a new period
//   tau_out/tau_valid_out       issued period and its strobe
//   voiced_out                  issued period came from the detector
//   window_toggle_out           ping-pong write half
//   dropped_frame_out           one-cycle pulse when a frame is abandoned
//   drop_count_out              saturating dropped-frame count
//   dbg_state_out               current sequencer state
module psola_frame_sequencer
    import psola_pkg::*;
#(
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int TAU_WIDTH   = DEF_TAU_WIDTH,
    parameter int TAU_MIN     = DEF_TAU_MIN,
    parameter int TAU_MAX     = DEF_TAU_MAX,
    parameter int DEFAULT_TAU = DEF_DEFAULT_TAU
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 sample_valid_in,
    output logic                 pitch_start_out,
    input  logic [TAU_WIDTH-1:0] pitch_tau_in,
    input  logic                 pitch_valid_in,
    input  logic                 psola_idle_in,
    output logic [TAU_WIDTH-1:0] tau_out,
    output logic                 tau_valid_out,
    output logic                 voiced_out,
    output logic                 window_toggle_out,
    output logic                 dropped_frame_out,
    output logic [7:0]           drop_count_out,
    output seq_state_e           dbg_state_out
);

    localparam logic [TAU_WIDTH-1:0] TAU_MIN_W     = TAU_WIDTH'(TAU_MIN);
    localparam logic [TAU_WIDTH-1:0] TAU_MAX_W     = TAU_WIDTH'(TAU_MAX);
    localparam logic [TAU_WIDTH-1:0] DEFAULT_TAU_W = TAU_WIDTH'(DEFAULT_TAU);

    seq_state_e           state_q, state_d;
    logic [TAU_WIDTH-1:0] cand_q, cand_d;
    logic                 cand_voiced_q, cand_voiced_d;
    logic [TAU_WIDTH-1:0] last_good_q, last_good_d;
    logic                 pitch_start_q, pitch_start_d;
    logic [TAU_WIDTH-1:0] tau_q, tau_d;
    logic                 tau_valid_q, tau_valid_d;
    logic                 voiced_q, voiced_d;
    logic                 dropped_q, dropped_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic boundary;
    logic issue;
    logic drop;
    logic tau_ok;

    window_counter #(
        .WINDOW_SIZE (WINDOW_SIZE)
    ) u_window_counter (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_valid_in (sample_valid_in),
        .boundary_out    (boundary),
        .toggle_out      (window_toggle_out)
    );

    // Issue wins over a coincident boundary; a boundary otherwise abandons
    // any frame still in flight.
    assign issue  = (state_q == WAIT_PSOLA) && psola_idle_in;
    assign drop   = boundary && ((state_q == WAIT_PITCH) ||
                                 ((state_q == WAIT_PSOLA) && !psola_idle_in));
    assign tau_ok = (pitch_tau_in >= TAU_MIN_W) && (pitch_tau_in <= TAU_MAX_W);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (boundary) state_d = WAIT_PITCH;
            end
            WAIT_PITCH: begin
                if (boundary)            state_d = WAIT_PITCH;
                else if (pitch_valid_in) state_d = WAIT_PSOLA;
            end
            WAIT_PSOLA: begin
                if (psola_idle_in) state_d = boundary ? WAIT_PITCH : IDLE;
                else if (boundary) state_d = WAIT_PITCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cand_d        = cand_q;
        cand_voiced_d = cand_voiced_q;
        last_good_d   = last_good_q;
        tau_d         = tau_q;
        voiced_d      = voiced_q;
        pitch_start_d = boundary;
        tau_valid_d   = issue;
        dropped_d     = drop;
        drop_cnt_d    = drop_cnt_q;

        if ((state_q == WAIT_PITCH) && pitch_valid_in && !boundary) begin
            cand_d        = tau_ok ? pitch_tau_in : last_good_q;
            cand_voiced_d = tau_ok;
        end

        if (issue) begin
            tau_d    = cand_q;
            voiced_d = cand_voiced_q;
            if (cand_voiced_q) last_good_d = cand_q;
        end

        if (drop && (drop_cnt_q != DROP_COUNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cand_q        <= '0;
            cand_voiced_q <= 1'b0;
            last_good_q   <= DEFAULT_TAU_W;
            pitch_start_q <= 1'b0;
            tau_q         <= '0;
            tau_valid_q   <= 1'b0;
            voiced_q      <= 1'b0;
            dropped_q     <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            cand_q        <= cand_d;
            cand_voiced_q <= cand_voiced_d;
            last_good_q   <= last_good_d;
            pitch_start_q <= pitch_start_d;
            tau_q         <= tau_d;
            tau_valid_q   <= tau_valid_d;
            voiced_q      <= voiced_d;
            dropped_q     <= dropped_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign pitch_start_out   = pitch_start_q;
    assign tau_out           = tau_q;
    assign tau_valid_out     = tau_valid_q;
    assign voiced_out        = voiced_q;
    assign dropped_frame_out = dropped_q;
    assign drop_count_out    = drop_cnt_q;
    assign dbg_state_out     = state_q;

endmodule

// File: tb/tb_psola_frame_sequencer.sv
module tb_psola_frame_sequencer;
    import psola_pkg::*;

    localparam int WS = 16;
    localparam int TW = 12;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic          pitch_start_out;
    logic [TW-1:0] pitch_tau_in = '0;
    logic          pitch_valid_in = 1'b0;
    logic          psola_idle_in = 1'b0;
    logic [TW-1:0] tau_out;
    logic          tau_valid_out;
    logic          voiced_out;
    logic          window_toggle_out;
    logic          dropped_frame_out;
    logic [7:0]    drop_count_out;
    seq_state_e    dbg_state_out;

    int tests = 0;
    int fails = 0;
    logic exp_toggle = 1'b0;

    psola_frame_sequencer #(
        .WINDOW_SIZE (WS),
        .TAU_WIDTH   (TW),
        .TAU_MIN     (20),
        .TAU_MAX     (1024),
        .DEFAULT_TAU (200)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .sample_valid_in   (sample_valid_in),
        .pitch_start_out   (pitch_start_out),
        .pitch_tau_in      (pitch_tau_in),
        .pitch_valid_in    (pitch_valid_in),
        .psola_idle_in     (psola_idle_in),
        .tau_out           (tau_out),
        .tau_valid_out     (tau_valid_out),
        .voiced_out        (voiced_out),
        .window_toggle_out (window_toggle_out),
        .dropped_frame_out (dropped_frame_out),
        .drop_count_out    (drop_count_out),
        .dbg_state_out     (dbg_state_out)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one full window of samples; the last one is the boundary.
    task automatic send_window(input string tag, input bit do_chk);
        for (int i = 0; i < WS; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        sample_valid_in = 1'b0;
        exp_toggle = ~exp_toggle;
        if (do_chk) begin
            chk({tag, ".start"},  32'(pitch_start_out),   32'd1);
            chk({tag, ".toggle"}, 32'(window_toggle_out), 32'(exp_toggle));
        end
    endtask

    // Detector returns a period with the core idle; expect issue 2 cycles later.
    task automatic pitch_and_issue(input string tag, input logic [TW-1:0] tau,
                                   input logic [TW-1:0] exp_tau, input logic exp_voiced);
        psola_idle_in  = 1'b1;
        pitch_valid_in = 1'b1;
        pitch_tau_in   = tau;
        step();
        pitch_valid_in = 1'b0;
        chk({tag, ".state1"}, 32'(dbg_state_out), 32'(WAIT_PSOLA));
        chk({tag, ".tv1"},    32'(tau_valid_out), 32'd0);
        step();
        chk({tag, ".tv2"},    32'(tau_valid_out), 32'd1);
        chk({tag, ".tau"},    32'(tau_out),       32'(exp_tau));
        chk({tag, ".voiced"}, 32'(voiced_out),    32'(exp_voiced));
        step();
        chk({tag, ".tv3"},    32'(tau_valid_out), 32'd0);
        chk({tag, ".hold"},   32'(tau_out),       32'(exp_tau));
        chk({tag, ".idle"},   32'(dbg_state_out), 32'(IDLE));
    endtask

    initial begin
        // Reset
        #12;
        chk("rst.state",   32'(dbg_state_out),     32'(IDLE));
        chk("rst.start",   32'(pitch_start_out),   32'd0);
        chk("rst.tau",     32'(tau_out),           32'd0);
        chk("rst.tv",      32'(tau_valid_out),     32'd0);
        chk("rst.voiced",  32'(voiced_out),        32'd0);
        chk("rst.toggle",  32'(window_toggle_out), 32'd0);
        chk("rst.dropped", 32'(dropped_frame_out), 32'd0);
        chk("rst.dcnt",    32'(drop_count_out),    32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();

        // First window: no start after 15 samples, start one cycle after the 16th
        for (int i = 0; i < WS - 1; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        chk("win1.nostart", 32'(pitch_start_out),   32'd0);
        chk("win1.toggle0", 32'(window_toggle_out), 32'd0);
        step();
        sample_valid_in = 1'b0;
        exp_toggle = 1'b1;
        chk("win1.start",  32'(pitch_start_out),   32'd1);
        chk("win1.toggle", 32'(window_toggle_out), 32'd1);
        chk("win1.state",  32'(dbg_state_out),     32'(WAIT_PITCH));
        step();
        chk("win1.pulse", 32'(pitch_start_out), 32'd0);
        pitch_and_issue("f5", 12'd5, 12'd200, 1'b0);

        // Fallback and voiced frames; fallback uses last good period
        send_window("w2000", 1'b1);
        pitch_and_issue("f2000", 12'd2000, 12'd200, 1'b0);
        send_window("w100", 1'b1);
        pitch_and_issue("f100", 12'd100, 12'd100, 1'b1);
        send_window("w150", 1'b1);
        pitch_and_issue("f150", 12'd150, 12'd150, 1'b1);
        send_window("w3000", 1'b1);
        pitch_and_issue("f3000", 12'd3000, 12'd150, 1'b0);
        send_window("w20", 1'b1);
        pitch_and_issue("f20", 12'd20, 12'd20, 1'b1);
        send_window("w1024", 1'b1);
        pitch_and_issue("f1024", 12'd1024, 12'd1024, 1'b1);
        send_window("w19", 1'b1);
        pitch_and_issue("f19", 12'd19, 12'd1024, 1'b0);
        send_window("w1025", 1'b1);
        pitch_and_issue("f1025", 12'd1025, 12'd1024, 1'b0);

        // Core stays busy through a whole window: frame dropped
        psola_idle_in = 1'b0;
        send_window("wdrop", 1'b1);
        pitch_valid_in = 1'b1;
        pitch_tau_in   = 12'd100;
        step();
        pitch_valid_in = 1'b0;
        chk("drop.wpsola", 32'(dbg_state_out), 32'(WAIT_PSOLA));
        send_window("drop", 1'b1);
        chk("drop.pulse", 32'(dropped_frame_out), 32'd1);
        chk("drop.cnt",   32'(drop_count_out),    32'd1);
        chk("drop.tv",    32'(tau_valid_out),     32'd0);
        chk("drop.tau",   32'(tau_out),           32'd1024);
        chk("drop.state", 32'(dbg_state_out),     32'(WAIT_PITCH));
        step();
        chk("drop.pulse_end", 32'(dropped_frame_out), 32'd0);
        pitch_and_issue("f300", 12'd300, 12'd300, 1'b1);

        // Boundary coincident with pitch_valid_in: boundary wins
        psola_idle_in = 1'b0;
        send_window("wsim1", 1'b1);
        for (int i = 0; i < WS - 1; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        pitch_valid_in = 1'b1;
        pitch_tau_in   = 12'd400;
        step();
        sample_valid_in = 1'b0;
        pitch_valid_in  = 1'b0;
        exp_toggle = ~exp_toggle;
        chk("sim1.drop",   32'(dropped_frame_out), 32'd1);
        chk("sim1.cnt",    32'(drop_count_out),    32'd2);
        chk("sim1.start",  32'(pitch_start_out),   32'd1);
        chk("sim1.toggle", 32'(window_toggle_out), 32'(exp_toggle));
        step();
        chk("sim1.state", 32'(dbg_state_out), 32'(WAIT_PITCH));

        // Boundary coincident with psola_idle_in: issue wins, no drop
        pitch_valid_in = 1'b1;
        pitch_tau_in   = 12'd500;
        step();
        pitch_valid_in = 1'b0;
        for (int i = 0; i < WS - 1; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        chk("sim2.waiting", 32'(tau_valid_out), 32'd0);
        psola_idle_in = 1'b1;
        step();
        sample_valid_in = 1'b0;
        exp_toggle = ~exp_toggle;
        chk("sim2.tv",     32'(tau_valid_out),     32'd1);
        chk("sim2.tau",    32'(tau_out),           32'd500);
        chk("sim2.voiced", 32'(voiced_out),        32'd1);
        chk("sim2.drop",   32'(dropped_frame_out), 32'd0);
        chk("sim2.cnt",    32'(drop_count_out),    32'd2);
        chk("sim2.start",  32'(pitch_start_out),   32'd1);
        chk("sim2.state",  32'(dbg_state_out),     32'(WAIT_PITCH));
        step();
        chk("sim2.tv_once", 32'(tau_valid_out), 32'd0);
        psola_idle_in = 1'b0;

        // Saturation: 300 consecutive dropped windows
        for (int w = 0; w < 300; w++) begin
            send_window("sat", 1'b0);
            if (w == 252) chk("sat.at255", 32'(drop_count_out), 32'd255);
        end
        chk("sat.cnt",    32'(drop_count_out),    32'd255);
        chk("sat.pulse",  32'(dropped_frame_out), 32'd1);
        chk("sat.toggle", 32'(window_toggle_out), 32'(exp_toggle));

        // Asynchronous reset in WAIT_PSOLA, mid-window
        step();
        pitch_valid_in = 1'b1;
        pitch_tau_in   = 12'd600;
        step();
        pitch_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        sample_valid_in = 1'b0;
        chk("ar.pre_state", 32'(dbg_state_out), 32'(WAIT_PSOLA));
        rst_n_in = 1'b0;
        #2;
        chk("ar.state",   32'(dbg_state_out),     32'(IDLE));
        chk("ar.tau",     32'(tau_out),           32'd0);
        chk("ar.tv",      32'(tau_valid_out),     32'd0);
        chk("ar.toggle",  32'(window_toggle_out), 32'd0);
        chk("ar.dcnt",    32'(drop_count_out),    32'd0);
        chk("ar.dropped", 32'(dropped_frame_out), 32'd0);
        chk("ar.start",   32'(pitch_start_out),   32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        exp_toggle = 1'b0;
        step();

        // First boundary after release needs a full window; last_good back to default
        for (int i = 0; i < WS - 1; i++) begin
            sample_valid_in = 1'b1;
            step();
        end
        chk("ar.nostart", 32'(pitch_start_out), 32'd0);
        step();
        sample_valid_in = 1'b0;
        chk("ar.start2",  32'(pitch_start_out),   32'd1);
        chk("ar.toggle2", 32'(window_toggle_out), 32'd1);
        pitch_and_issue("ar.f700", 12'd1100, 12'd200, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
